// File: rtl/task_mailbox_slave.sv
// task_mailbox_slave: AXI-lite mailbox holding one task address per node.
// The host posts into empty slots; a node clears its slot by writing zero,
// which raises a one-cycle finish pulse back to the host.
module task_mailbox_slave #(
    parameter int unsigned NODES           = 32,
    parameter int unsigned ID_MSB          = 6,
    parameter int unsigned ID_LSB          = 2,
    parameter int unsigned INDEX_PROG      = 7,
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned AXI_WSTRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic [AXI_ADDR_WIDTH-1:0]  i_s_axi_awaddr,
    input  logic                       i_s_axi_awvalid,
    output logic                       o_s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]  i_s_axi_wdata,
    input  logic [AXI_WSTRB_WIDTH-1:0] i_s_axi_wstrb,
    input  logic                       i_s_axi_wvalid,
    output logic                       o_s_axi_wready,
    output logic [1:0]                 o_s_axi_bresp,
    output logic                       o_s_axi_bvalid,
    input  logic                       i_s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]  i_s_axi_araddr,
    input  logic                       i_s_axi_arvalid,
    output logic                       o_s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]  o_s_axi_rdata,
    output logic [1:0]                 o_s_axi_rresp,
    output logic                       o_s_axi_rvalid,
    input  logic                       i_s_axi_rready,
    input  logic                       i_assign_valid,
    output logic                       o_assign_ready,
    input  logic [4:0]                 i_assign_node,
    input  logic [AXI_DATA_WIDTH-1:0]  i_assign_addr,
    output logic                       o_fin_valid,
    output logic [4:0]                 o_fin_node,
    output logic [NODES-1:0]           o_busy
);

    localparam int unsigned IDX_W       = (NODES > 1) ? $clog2(NODES) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_COLLECT,
        S_WR_RESP,
        S_RD_RESP
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic                        r_awready, r_wready, r_arready;
    logic                        r_bvalid, r_rvalid;
    logic [1:0]                  r_bresp, r_rresp;
    logic [AXI_DATA_WIDTH-1:0]   r_rdata;

    // Half-collected write and a read parked behind a write.
    logic                        r_aw_got, r_w_got;
    logic                        r_aw_ok;
    logic [IDX_W-1:0]            r_aw_id;
    logic [AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [AXI_WSTRB_WIDTH-1:0]  r_wstrb;
    logic                        r_rd_pend;
    logic                        r_ar_ok;
    logic [IDX_W-1:0]            r_ar_id;

    logic [AXI_DATA_WIDTH-1:0]   r_slot [NODES];
    logic [AXI_DATA_WIDTH-1:0]   w_slot_nxt [NODES];
    logic [NODES-1:0]            r_busy;
    logic                        r_fin_valid;
    logic [4:0]                  r_fin_node;

    logic                        w_aw_hs, w_w_hs, w_ar_hs;
    logic                        w_aw_ok, w_ar_ok;
    logic [IDX_W-1:0]            w_aw_id, w_ar_id;
    logic                        w_cm_ok;
    logic [IDX_W-1:0]            w_cm_id;
    logic [AXI_DATA_WIDTH-1:0]   w_cm_data;
    logic [AXI_WSTRB_WIDTH-1:0]  w_cm_strb;
    logic [AXI_DATA_WIDTH-1:0]   w_merged;
    logic                        w_rd_ok;
    logic [IDX_W-1:0]            w_rd_id;
    logic                        w_commit, w_rd_start;
    logic                        w_aw_got_nxt, w_w_got_nxt, w_rd_pend_nxt;
    logic                        w_awready_nxt, w_wready_nxt, w_arready_nxt;
    logic                        w_assign_fire, w_fin_set;
    logic                        w_unused_addr;

    // Byte-lane merge of write data into the current slot value.
    function automatic logic [AXI_DATA_WIDTH-1:0] f_merge(
        input logic [AXI_DATA_WIDTH-1:0]  old_v,
        input logic [AXI_DATA_WIDTH-1:0]  new_v,
        input logic [AXI_WSTRB_WIDTH-1:0] strb
    );
        logic [AXI_DATA_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < int'(AXI_WSTRB_WIDTH); b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    assign w_aw_hs = i_s_axi_awvalid & r_awready;
    assign w_w_hs  = i_s_axi_wvalid  & r_wready;
    assign w_ar_hs = i_s_axi_arvalid & r_arready;

    // Address decode: control region, prog bit, node id in range.
    assign w_aw_ok = i_s_axi_awaddr[AXI_ADDR_WIDTH-1] & i_s_axi_awaddr[INDEX_PROG]
                   & (32'(i_s_axi_awaddr[ID_MSB:ID_LSB]) < NODES);
    assign w_ar_ok = i_s_axi_araddr[AXI_ADDR_WIDTH-1] & i_s_axi_araddr[INDEX_PROG]
                   & (32'(i_s_axi_araddr[ID_MSB:ID_LSB]) < NODES);
    assign w_aw_id = IDX_W'(i_s_axi_awaddr[ID_MSB:ID_LSB]);
    assign w_ar_id = IDX_W'(i_s_axi_araddr[ID_MSB:ID_LSB]);
    assign w_unused_addr = ^{i_s_axi_awaddr, i_s_axi_araddr};

    // Commit operands come from this cycle's handshake or the latched half.
    assign w_cm_ok   = w_aw_hs ? w_aw_ok       : r_aw_ok;
    assign w_cm_id   = w_aw_hs ? w_aw_id       : r_aw_id;
    assign w_cm_data = w_w_hs  ? i_s_axi_wdata : r_wdata;
    assign w_cm_strb = w_w_hs  ? i_s_axi_wstrb : r_wstrb;
    assign w_merged  = f_merge(r_slot[w_cm_id], w_cm_data, w_cm_strb);

    assign w_rd_ok = r_rd_pend ? r_ar_ok : w_ar_ok;
    assign w_rd_id = r_rd_pend ? r_ar_id : w_ar_id;

    // Host may post only into an empty slot not being written this cycle.
    assign o_assign_ready = (32'(i_assign_node) < NODES)
                          && (r_slot[IDX_W'(i_assign_node)] == '0)
                          && !(w_commit && w_cm_ok && (5'(w_cm_id) == i_assign_node));
    assign w_assign_fire  = i_assign_valid & o_assign_ready;

    // State register.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, commit/read strobes and next channel readies.
    always_comb begin
        w_state_nxt   = r_state;
        w_commit      = 1'b0;
        w_rd_start    = 1'b0;
        w_aw_got_nxt  = r_aw_got;
        w_w_got_nxt   = r_w_got;
        w_rd_pend_nxt = r_rd_pend;
        case (r_state)
            S_IDLE: begin
                if (w_aw_hs || w_w_hs) begin
                    if (w_ar_hs) w_rd_pend_nxt = 1'b1;
                    if (w_aw_hs && w_w_hs) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_WR_RESP;
                    end else begin
                        w_aw_got_nxt = w_aw_hs;
                        w_w_got_nxt  = w_w_hs;
                        w_state_nxt  = S_WR_COLLECT;
                    end
                end else if (r_rd_pend || w_ar_hs) begin
                    w_rd_start    = 1'b1;
                    w_rd_pend_nxt = 1'b0;
                    w_state_nxt   = S_RD_RESP;
                end
            end
            S_WR_COLLECT: begin
                if (w_aw_hs || w_w_hs) begin
                    w_commit     = 1'b1;
                    w_aw_got_nxt = 1'b0;
                    w_w_got_nxt  = 1'b0;
                    w_state_nxt  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (i_s_axi_bready) w_state_nxt = S_IDLE;
            end
            S_RD_RESP: begin
                if (i_s_axi_rready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_awready_nxt = (w_state_nxt == S_IDLE) || ((w_state_nxt == S_WR_COLLECT) && !w_aw_got_nxt);
        w_wready_nxt  = (w_state_nxt == S_IDLE) || ((w_state_nxt == S_WR_COLLECT) && !w_w_got_nxt);
        w_arready_nxt = (w_state_nxt == S_IDLE) && !w_rd_pend_nxt;
    end

    // AXI channel registers and latched transaction fields.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_aw_ok   <= 1'b0;
            r_aw_id   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rd_pend <= 1'b0;
            r_ar_ok   <= 1'b0;
            r_ar_id   <= '0;
        end else begin
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_arready <= w_arready_nxt;
            r_bvalid  <= (w_state_nxt == S_WR_RESP);
            r_rvalid  <= (w_state_nxt == S_RD_RESP);
            r_aw_got  <= w_aw_got_nxt;
            r_w_got   <= w_w_got_nxt;
            r_rd_pend <= w_rd_pend_nxt;
            if (w_aw_hs) begin
                r_aw_ok <= w_aw_ok;
                r_aw_id <= w_aw_id;
            end
            if (w_w_hs) begin
                r_wdata <= i_s_axi_wdata;
                r_wstrb <= i_s_axi_wstrb;
            end
            if (w_ar_hs) begin
                r_ar_ok <= w_ar_ok;
                r_ar_id <= w_ar_id;
            end
            if (w_commit) r_bresp <= w_cm_ok ? RESP_OKAY : RESP_DECERR;
            if (w_rd_start) begin
                r_rresp <= w_rd_ok ? RESP_OKAY : RESP_DECERR;
                r_rdata <= w_rd_ok ? r_slot[w_rd_id] : '0;
            end
        end
    end

    // Slot update: host assign, then AXI commit (commit wins on the same slot).
    always_comb begin
        w_slot_nxt = r_slot;
        w_fin_set  = 1'b0;
        if (w_assign_fire) w_slot_nxt[IDX_W'(i_assign_node)] = i_assign_addr;
        if (w_commit && w_cm_ok) begin
            w_slot_nxt[w_cm_id] = w_merged;
            w_fin_set = (r_slot[w_cm_id] != '0) && (w_merged == '0);
        end
    end

    // Slot storage, busy vector and finish pulse.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < int'(NODES); i++) r_slot[i] <= '0;
            r_busy      <= '0;
            r_fin_valid <= 1'b0;
            r_fin_node  <= '0;
        end else begin
            for (int i = 0; i < int'(NODES); i++) begin
                r_slot[i] <= w_slot_nxt[i];
                r_busy[i] <= |w_slot_nxt[i];
            end
            r_fin_valid <= w_fin_set;
            if (w_fin_set) r_fin_node <= 5'(w_cm_id);
        end
    end

    assign o_s_axi_awready = r_awready;
    assign o_s_axi_wready  = r_wready;
    assign o_s_axi_arready = r_arready;
    assign o_s_axi_bvalid  = r_bvalid;
    assign o_s_axi_bresp   = r_bresp;
    assign o_s_axi_rvalid  = r_rvalid;
    assign o_s_axi_rresp   = r_rresp;
    assign o_s_axi_rdata   = r_rdata;
    assign o_fin_valid     = r_fin_valid;
    assign o_fin_node      = r_fin_node;
    assign o_busy          = r_busy;

endmodule
